// File: rtl/demux_merge_2to1_16bit.sv
// demux_merge_2to1_16bit
//   Two-channel round-robin merge. Each producer channel feeds its own small
//   FIFO; one word per cycle is popped into a registered output stage that
//   also carries the source channel index (out_sel) for reply routing.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in0_data/valid/ready  : channel 0 producer handshake (ready = FIFO 0 not full)
//   in1_data/valid/ready  : channel 1 producer handshake (ready = FIFO 1 not full)
//   out_data/sel/valid    : registered merged word, its source channel, valid flag
//   out_ready             : consumer accepts the current output word
module demux_merge_2to1_16bit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data [2];
  logic [WIDTH-1:0] head    [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_rdy;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;

  // Cleared by reset, set on the first edge afterwards: keeps both readies
  // low for the whole time rst_n is asserted even though the FIFOs are empty.
  logic             rdy_en_q;

  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             out_free;
  logic             pop_any;
  logic             gnt;

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_valid   = {in1_valid, in0_valid};

  // Ready depends only on the FIFO fill level (registered state), so a full
  // FIFO stays not-ready even in a cycle where it is being popped.
  assign in_rdy    = {rdy_en_q && !full[1], rdy_en_q && !full[0]};
  assign push      = in_valid & in_rdy;
  assign in0_ready = in_rdy[0];
  assign in1_ready = in_rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;

    assign full[g]  = (cnt_q == CW'(DEPTH));
    assign empty[g] = (cnt_q == '0);
    assign head[g]  = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[g]) wptr_q <= wptr_q + AW'(1);
        if (pop[g])  rptr_q <= rptr_q + AW'(1);
        case ({push[g], pop[g]})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q] <= in_data[g];
    end
  end

  // Round-robin: on contention the channel that did not win last time is
  // granted; otherwise whichever FIFO holds data. Only FIFO contents visible
  // at the start of the cycle take part, so there is no input-to-output bypass.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    pop_any  = out_free && !(&empty);
    if (!empty[0] && !empty[1]) gnt = !last_grant_q;
    else                        gnt = empty[0];
    pop = '0;
    if (pop_any) pop[gnt] = 1'b1;
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (out_free) begin
      out_valid_d = pop_any;
      if (pop_any) begin
        out_data_d   = gnt ? head[1] : head[0];
        out_sel_d    = gnt;
        last_grant_d = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_sel_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_merge_2to1_16bit.sv
module tb_demux_merge_2to1_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] in0_data, in1_data, out_data;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic        out_sel, out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: per-channel expected words, plus expected source order
  logic [15:0] q0[$], q1[$];
  logic        selq[$];
  // producer sources
  logic [15:0] src0[$], src1[$];
  int          idx0, idx1;
  bit          acc0_last, acc1_last;
  int          v_cnt, first_v, last_v;
  logic [15:0] hold;

  demux_merge_2to1_16bit #(.WIDTH(16), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_data (in0_data),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in1_data (in1_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_check();
    if (selq.size() != 0) check("sel_order", out_sel, selq.pop_front());
    if (out_sel == 1'b0) begin
      check("sb_nonempty0", (q0.size() != 0), 1);
      if (q0.size() != 0) check("out_data0", out_data, q0.pop_front());
    end else begin
      check("sb_nonempty1", (q1.size() != 0), 1);
      if (q1.size() != 0) check("out_data1", out_data, q1.pop_front());
    end
  endtask

  // One clock: note handshakes seen before the edge, then advance to edge+1.
  task automatic step();
    bit a0, a1, f;
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    f  = out_valid && out_ready;
    if (f)  sb_check();
    if (a0) q0.push_back(in0_data);
    if (a1) q1.push_back(in1_data);
    @(posedge clk);
    #1;
    acc0_last = a0;
    acc1_last = a1;
  endtask

  task automatic drive();
    in0_valid = (idx0 < src0.size());
    in0_data  = in0_valid ? src0[idx0] : 16'($urandom);
    in1_valid = (idx1 < src1.size());
    in1_data  = in1_valid ? src1[idx1] : 16'($urandom);
  endtask

  task automatic cyc();
    drive();
    step();
    if (acc0_last) idx0++;
    if (acc1_last) idx1++;
  endtask

  task automatic run(input int max_cyc);
    int c;
    c = 0; v_cnt = 0; first_v = -1; last_v = -1;
    while ((idx0 < src0.size() || idx1 < src1.size() || q0.size() != 0 ||
            q1.size() != 0 || out_valid) && c < max_cyc) begin
      cyc();
      c++;
      if (out_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("run_in_budget", (c < max_cyc), 1);
    check("src0_consumed", idx0, src0.size());
    check("src1_consumed", idx1, src1.size());
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("selq_drained", selq.size(), 0);
  endtask

  task automatic clear_sb();
    q0.delete(); q1.delete(); selq.delete();
    src0.delete(); src1.delete();
    idx0 = 0; idx1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    clear_sb();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    clear_sb();

    // reset held with random inputs
    repeat (3) begin
      in0_valid = 1'($urandom); in1_valid = 1'($urandom);
      in0_data = 16'($urandom); in1_data = 16'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sel", out_sel, 0);
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rel_in0_ready_pre", in0_ready, 0);
    check("rel_in1_ready_pre", in1_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in0_ready", in0_ready, 1);
    check("rel_in1_ready", in1_ready, 1);

    // single word, latency and no bypass
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 16'hA5A5;
    step();
    in0_valid = 1'b0;
    check("single_no_bypass", out_valid, 0);
    step();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 16'hA5A5);
    check("single_sel", out_sel, 0);
    step();
    check("single_gone", out_valid, 0);
    check("single_q0_empty", q0.size(), 0);

    // contention from reset: channel 0 wins first, then strict alternation
    do_reset();
    out_ready = 1'b1;
    src0 = '{16'h0001, 16'h0002, 16'h0003};
    src1 = '{16'h1001, 16'h1002, 16'h1003};
    selq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run(40);
    check("cont_count", v_cnt, 6);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    src0 = '{16'h2001, 16'h2002, 16'h2003};
    src1 = '{16'h3001, 16'h3002, 16'h3003};
    selq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cyc();
    cyc();
    check("bp_in0_ready_e2", in0_ready, 1);
    check("bp_in1_ready_e2", in1_ready, 0);
    check("bp_acc1_e2", idx1, 2);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 16'h2001);
    hold = out_data;
    cyc();
    check("bp_in0_ready_e3", in0_ready, 0);
    check("bp_acc0_e3", idx0, 3);
    repeat (2) begin
      cyc();
      check("bp_stable_data", out_data, hold);
      check("bp_stable_valid", out_valid, 1);
      check("bp_acc1_held", idx1, 2);
    end
    out_ready = 1'b1;
    cyc();
    check("bp_ready_rerise", in1_ready, 1);
    check("bp_next_sel", out_sel, 1);
    check("bp_next_data", out_data, 16'h3001);
    run(40);

    // single channel stream, no bubbles
    out_ready = 1'b1;
    clear_sb();
    for (int unsigned i = 0; i < 8; i++) begin
      src1.push_back(16'h7000 + 16'(i));
      selq.push_back(1'b1);
    end
    run(40);
    check("stream_count", v_cnt, 8);
    check("stream_span", last_v - first_v + 1, 8);

    // mid-operation reset discards buffered words
    do_reset();
    out_ready = 1'b0;
    src0 = '{16'h4001, 16'h4002};
    src1 = '{16'h5001, 16'h5002};
    repeat (3) cyc();
    in0_valid = 1'b0; in1_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_sel", out_sel, 0);
    check("mid_in0_ready", in0_ready, 0);
    check("mid_in1_ready", in1_ready, 0);
    clear_sb();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) begin
      step();
      check("post_rst_idle", out_valid, 0);
    end
    src1 = '{16'h6001};
    selq = '{1'b1};
    run(20);
    check("post_rst_count", v_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_merge_2to1_16bit.md
# demux_merge_2to1_16bit

Two-input merging arbiter: the return-path counterpart of the 1-to-2 16-bit demultiplexer. It collects 16-bit words from two independent producer channels, buffers each channel in a small FIFO, and selects one word per cycle onto a single registered output. Selection between the channels is round-robin. The output also carries the source channel index, so a downstream demultiplexer can route replies back using that index as its select.

## Interface
Parameters:
- WIDTH, 16, data width of every channel
- DEPTH, 2, entries per input FIFO (power of two, ≥2)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in0_data  input  WIDTH  channel 0 word
- in0_valid  input  1  channel 0 word present
- in0_ready  output  1  channel 0 FIFO can accept
- in1_data  input  WIDTH  channel 1 word
- in1_valid  input  1  channel 1 word present
- in1_ready  output  1  channel 1 FIFO can accept
- out_data  output  WIDTH  merged word (registered)
- out_sel  output  1  source channel of out_data (0 or 1)
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the output word

## Operation
- Input transfer on channel i: both inX_valid and inX_ready are high at a rising edge. The word is then written to FIFO i.
- inX_ready = !full_i. It depends only on that FIFO's count, never on out_ready, and there is no combinational path from inputs to outputs.
- A full FIFO keeps ready low even if it is popped in the same cycle.
- Output stage is "free" when out_valid==0, or when out_valid && out_ready (the current word is being consumed this cycle).
- When the output stage is free and at least one FIFO is non-empty, exactly one FIFO is popped. Its head word loads into out_data, its index into out_sel, and out_valid is set to 1.
- When the output stage is free and both FIFOs are empty, out_valid goes to 0. out_data and out_sel hold their last values.
- Arbitration uses a last_grant register:
  - Both FIFOs non-empty: grant the channel != last_grant.
  - Only one non-empty: grant that channel.
  - last_grant updates to the granted channel on every pop.
- Output is held stable while out_valid && !out_ready.
- Push and pop on the same FIFO in the same cycle leaves its count unchanged.
- There is no bypass: a word written into an empty FIFO is not visible to the arbiter until the next cycle.
- Words from one channel leave in arrival order. Nothing is dropped or duplicated.

Reset (rst_n low, asynchronous):
- Both FIFOs are emptied; pointers and counts are set to 0.
- out_valid=0, out_data=0, out_sel=0.
- last_grant=1, so channel 0 wins the first contention.
- in0_ready and in1_ready are forced to 0 while rst_n is low and go to 1 on the first edge after release.
- A reset asserted mid-transfer discards all buffered words. No partial state survives.

## Timing
- Latency: a word accepted at edge k appears with out_valid=1 after edge k+1, provided the output stage is free and the word wins arbitration.
- Throughput: one word per cycle sustained. With both channels streaming, output alternates 0,1,0,1.
- Backpressure: with out_ready low, FIFO i fills after DEPTH further accepted words, and inX_ready falls on the edge at which count reaches DEPTH.
- After out_ready returns high, the first pop occurs that same cycle, and ready re-rises after the following edge.
- Single channel active: that channel alone sustains one word per cycle. The round-robin pointer does not insert bubbles.

## Test plan
- Reset: hold rst_n low with random inputs → out_valid=0, out_data=0, out_sel=0, both readies 0. Release → both readies 1 after the first edge.
- Single word: in0_data=16'hA5A5 accepted at edge k, out_ready=1 → out_data=16'hA5A5, out_sel=0, out_valid=1 after edge k+1, then out_valid=0 after edge k+2.
- Contention: both channels present a word at the same edge, with channel 0 words 16'h0001..0003 and channel 1 words 16'h1001..1003 → output order 0001, 1001, 0002, 1002, 0003, 1003, with out_sel toggling 0,1,0,1,0,1.
- Backpressure: out_ready=0 while each channel offers 3 words with DEPTH=2 → in1_ready drops after 2 accepts. The third channel-1 word is held by its producer, the output is stable, and no loss occurs. With out_ready=1, all 5 accepted words are delivered in order.
- Single channel stream: only in1 active, 8 consecutive words → 8 back-to-back outputs with out_sel=1 and no gaps.
- Mid-operation reset: pulse rst_n low while both FIFOs hold words → all outputs return to reset values immediately, and none of the pre-reset words is ever emitted afterwards.
